// File: rtl/sram_seq_pkg.sv
// Shared types and constants for the SRAM phase sequencer and its port mux.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
// Contents: seq_state_type phase encoding, SRAM bus widths, default timer values.
package sram_seq_pkg;

  localparam int SRAM_ADDR_W     = 18;
  localparam int SRAM_DATA_W     = 16;
  localparam int TIMER_W_DEFAULT = 26;

  // One second of UART line silence at 50 MHz ends the load phase.
  localparam logic [25:0] UART_TIMEOUT_DEFAULT = 26'd49999999;
  localparam logic [25:0] WDOG_CYCLES_DEFAULT  = 26'd50000000;

  // Encoding is visible on the phase output, so values are fixed.
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_UART_RX = 3'd1,
    S_M2      = 3'd2,
    S_M1      = 3'd3,
    S_DONE    = 3'd4
  } seq_state_type;

endpackage

// File: rtl/sram_port_mux.sv
// Selects which requester drives the single SRAM controller port.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the selected requester owns the port for the whole phase.
// Ports: sel (current phase), per-requester address/data/we_n, VGA read address,
//        merged sram_address/sram_write_data/sram_we_n out.
module sram_port_mux
  import sram_seq_pkg::*;
(
  input  seq_state_type          sel,
  input  logic [SRAM_ADDR_W-1:0] uart_address,
  input  logic [SRAM_DATA_W-1:0] uart_write_data,
  input  logic                   uart_we_n,
  input  logic [SRAM_ADDR_W-1:0] m1_address,
  input  logic [SRAM_DATA_W-1:0] m1_write_data,
  input  logic                   m1_we_n,
  input  logic [SRAM_ADDR_W-1:0] m2_address,
  input  logic [SRAM_DATA_W-1:0] m2_write_data,
  input  logic                   m2_we_n,
  input  logic [SRAM_ADDR_W-1:0] vga_address,
  output logic [SRAM_ADDR_W-1:0] sram_address,
  output logic [SRAM_DATA_W-1:0] sram_write_data,
  output logic                   sram_we_n
);

  always_comb begin
    // VGA read-only access is the safe default: any phase that does not
    // explicitly own the port can never issue a write.
    sram_address    = vga_address;
    sram_write_data = '0;
    sram_we_n       = 1'b1;
    case (sel)
      S_UART_RX: begin
        sram_address    = uart_address;
        sram_write_data = uart_write_data;
        sram_we_n       = uart_we_n;
      end
      S_M2: begin
        sram_address    = m2_address;
        sram_write_data = m2_write_data;
        sram_we_n       = m2_we_n;
      end
      S_M1: begin
        sram_address    = m1_address;
        sram_write_data = m1_write_data;
        sram_we_n       = m1_we_n;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/sram_phase_sequencer.sv
// Owns the shared SRAM port and steps the decode flow UART load -> M2 -> M1 -> display.
// Latency: control outputs are registered (one cycle after the deciding input); SRAM mux is combinational from state.
// Backpressure: milestones hold the port until their finish pulse; optional SEQ_WATCHDOG_EN bounds M1/M2 length.
// Ports: CLOCK_50_I/resetn; UART_RX_I start-bit detect and rearm pushbutton; UART/M1/M2 SRAM requests and
//        VGA read address in; UART init/enable pulses, VGA_enable, M1/M2 start out; merged SRAM port out;
//        phase (state encoding) and sticky seq_error out.
// Build option: define SEQ_WATCHDOG_EN to compile in the M-phase watchdog and the WDOG_CYCLES parameter.
module sram_phase_sequencer
  import sram_seq_pkg::*;
#(
  parameter int                 TIMER_W      = TIMER_W_DEFAULT,
  parameter logic [TIMER_W-1:0] UART_TIMEOUT = TIMER_W'(UART_TIMEOUT_DEFAULT)
`ifdef SEQ_WATCHDOG_EN
  ,
  parameter logic [TIMER_W-1:0] WDOG_CYCLES  = TIMER_W'(WDOG_CYCLES_DEFAULT)
`endif
)(
  input  logic                   CLOCK_50_I,
  input  logic                   resetn,
  input  logic                   UART_RX_I,
  input  logic                   rearm,
  input  logic [SRAM_ADDR_W-1:0] UART_SRAM_address,
  input  logic [SRAM_DATA_W-1:0] UART_SRAM_write_data,
  input  logic                   UART_SRAM_we_n,
  output logic                   UART_rx_initialize,
  output logic                   UART_rx_enable,
  input  logic [SRAM_ADDR_W-1:0] VGA_SRAM_address,
  output logic                   VGA_enable,
  input  logic [SRAM_ADDR_W-1:0] M1_SRAM_address,
  input  logic [SRAM_DATA_W-1:0] M1_SRAM_write_data,
  input  logic                   M1_SRAM_we_n,
  input  logic [SRAM_ADDR_W-1:0] M2_SRAM_address,
  input  logic [SRAM_DATA_W-1:0] M2_SRAM_write_data,
  input  logic                   M2_SRAM_we_n,
  output logic                   M1_start,
  output logic                   M2_start,
  input  logic                   M1_finish,
  input  logic                   M2_finish,
  output logic [SRAM_ADDR_W-1:0] SRAM_address,
  output logic [SRAM_DATA_W-1:0] SRAM_write_data,
  output logic                   SRAM_we_n,
  output logic [2:0]             phase,
  output logic                   seq_error
);

  seq_state_type      state_q, state_d;
  logic               m1_start_q, m1_start_d;
  logic               m2_start_q, m2_start_d;
  logic               rx_init_q, rx_init_d;
  logic               rx_en_q, rx_en_d;
  logic               vga_en_q, vga_en_d;
  logic               decoded_q, decoded_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               wdog_expired;

`ifdef SEQ_WATCHDOG_EN
  logic [TIMER_W-1:0] wdog_q, wdog_d;
  logic               seq_error_q, seq_error_d;

  // Fires on the last allowed cycle so a phase lasts at most WDOG_CYCLES cycles.
  assign wdog_expired = (wdog_q == (WDOG_CYCLES - 1'b1));

  always_comb begin
    wdog_d      = '0;
    seq_error_d = seq_error_q;
    // Counter restarts on every entry into an M phase, including M2 -> M1.
    if ((state_d == S_M2 || state_d == S_M1) && (state_d == state_q))
      wdog_d = wdog_q + 1'b1;
    if (state_q == S_DONE && rearm)
      seq_error_d = 1'b0;
    else if (wdog_expired &&
             ((state_q == S_M2 && !M2_finish) || (state_q == S_M1 && !M1_finish)))
      seq_error_d = 1'b1;
  end

  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      wdog_q      <= '0;
      seq_error_q <= 1'b0;
    end else begin
      wdog_q      <= wdog_d;
      seq_error_q <= seq_error_d;
    end
  end

  assign seq_error = seq_error_q;
`else
  assign wdog_expired = 1'b0;
  assign seq_error    = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    m1_start_d = m1_start_q;
    m2_start_d = m2_start_q;
    decoded_d  = decoded_q;
    timer_d    = '0;
    rx_init_d  = 1'b0;
    // Enable always trails initialise by exactly one cycle.
    rx_en_d    = rx_init_q;
    case (state_q)
      S_IDLE: begin
        if (!UART_RX_I && !decoded_q) begin
          state_d   = S_UART_RX;
          rx_init_d = 1'b1;
        end
      end
      S_UART_RX: begin
        // A write in the same cycle as the timeout keeps the load alive.
        if (!UART_SRAM_we_n) begin
          timer_d = '0;
        end else if (timer_q == UART_TIMEOUT) begin
          state_d    = S_M2;
          m2_start_d = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_M2: begin
        if (M2_finish) begin
          m2_start_d = 1'b0;
          m1_start_d = 1'b1;
          state_d    = S_M1;
        end else if (wdog_expired) begin
          m2_start_d = 1'b0;
          decoded_d  = 1'b1;
          state_d    = S_DONE;
        end
      end
      S_M1: begin
        if (M1_finish || wdog_expired) begin
          m1_start_d = 1'b0;
          decoded_d  = 1'b1;
          state_d    = S_DONE;
        end
      end
      S_DONE: begin
        if (rearm) begin
          decoded_d = 1'b0;
          state_d   = S_IDLE;
        end
      end
      default: begin
        state_d    = S_IDLE;
        m1_start_d = 1'b0;
        m2_start_d = 1'b0;
      end
    endcase
    // Display fetches only while nobody else owns the SRAM port.
    vga_en_d = (state_d == S_IDLE) || (state_d == S_DONE);
  end

  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      m1_start_q <= 1'b0;
      m2_start_q <= 1'b0;
      rx_init_q  <= 1'b0;
      rx_en_q    <= 1'b0;
      vga_en_q   <= 1'b1;
      decoded_q  <= 1'b0;
      timer_q    <= '0;
    end else begin
      state_q    <= state_d;
      m1_start_q <= m1_start_d;
      m2_start_q <= m2_start_d;
      rx_init_q  <= rx_init_d;
      rx_en_q    <= rx_en_d;
      vga_en_q   <= vga_en_d;
      decoded_q  <= decoded_d;
      timer_q    <= timer_d;
    end
  end

  assign M1_start           = m1_start_q;
  assign M2_start           = m2_start_q;
  assign UART_rx_initialize = rx_init_q;
  assign UART_rx_enable     = rx_en_q;
  assign VGA_enable         = vga_en_q;
  assign phase              = state_q;

  sram_port_mux u_port_mux (
    .sel             (state_q),
    .uart_address    (UART_SRAM_address),
    .uart_write_data (UART_SRAM_write_data),
    .uart_we_n       (UART_SRAM_we_n),
    .m1_address      (M1_SRAM_address),
    .m1_write_data   (M1_SRAM_write_data),
    .m1_we_n         (M1_SRAM_we_n),
    .m2_address      (M2_SRAM_address),
    .m2_write_data   (M2_SRAM_write_data),
    .m2_we_n         (M2_SRAM_we_n),
    .vga_address     (VGA_SRAM_address),
    .sram_address    (SRAM_address),
    .sram_write_data (SRAM_write_data),
    .sram_we_n       (SRAM_we_n)
  );

endmodule

// File: tb/tb_sram_phase_sequencer.sv
// Directed bench for sram_phase_sequencer with a short UART timeout (100) and watchdog (50).
// Latency: checks sample 1 time unit after each rising edge; inputs change at the same point.
// Backpressure: milestone finish pulses are driven by hand to walk the phases.
module tb_sram_phase_sequencer;

  logic        clk;
  logic        resetn;
  logic        uart_rx;
  logic        rearm;
  logic [17:0] uart_addr, vga_addr, m1_addr, m2_addr;
  logic [15:0] uart_wdat, m1_wdat, m2_wdat;
  logic        uart_we_n, m1_we_n, m2_we_n;
  logic        rx_init, rx_en, vga_en;
  logic        m1_start, m2_start, m1_finish, m2_finish;
  logic [17:0] sram_addr;
  logic [15:0] sram_wdat;
  logic        sram_we_n;
  logic [2:0]  phase;
  logic        seq_error;

  int tests  = 0;
  int errors = 0;

  sram_phase_sequencer #(
    .TIMER_W      (26),
    .UART_TIMEOUT (26'd100)
`ifdef SEQ_WATCHDOG_EN
    ,
    .WDOG_CYCLES  (26'd50)
`endif
  ) dut (
    .CLOCK_50_I           (clk),
    .resetn               (resetn),
    .UART_RX_I            (uart_rx),
    .rearm                (rearm),
    .UART_SRAM_address    (uart_addr),
    .UART_SRAM_write_data (uart_wdat),
    .UART_SRAM_we_n       (uart_we_n),
    .UART_rx_initialize   (rx_init),
    .UART_rx_enable       (rx_en),
    .VGA_SRAM_address     (vga_addr),
    .VGA_enable           (vga_en),
    .M1_SRAM_address      (m1_addr),
    .M1_SRAM_write_data   (m1_wdat),
    .M1_SRAM_we_n         (m1_we_n),
    .M2_SRAM_address      (m2_addr),
    .M2_SRAM_write_data   (m2_wdat),
    .M2_SRAM_we_n         (m2_we_n),
    .M1_start             (m1_start),
    .M2_start             (m2_start),
    .M1_finish            (m1_finish),
    .M2_finish            (m2_finish),
    .SRAM_address         (sram_addr),
    .SRAM_write_data      (sram_wdat),
    .SRAM_we_n            (sram_we_n),
    .phase                (phase),
    .seq_error            (seq_error)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bounded wait for a phase; an expired budget shows up as a failed check.
  task automatic wait_phase(input logic [2:0] p, input int max_cycles);
    for (int i = 0; i < max_cycles && phase !== p; i++) tick();
    chk("wait_phase", {29'd0, phase}, {29'd0, p});
  endtask

  initial begin
    resetn    = 1'b0;
    uart_rx   = 1'b1;
    rearm     = 1'b0;
    uart_addr = 18'h00AAA; uart_wdat = 16'h1111; uart_we_n = 1'b1;
    m1_addr   = 18'h00200; m1_wdat   = 16'h3333; m1_we_n   = 1'b1;
    m2_addr   = 18'h00100; m2_wdat   = 16'h2222; m2_we_n   = 1'b1;
    vga_addr  = 18'h23E00;
    m1_finish = 1'b0;
    m2_finish = 1'b0;

    // Reset state
    tick(); tick();
    chk("rst_phase", {29'd0, phase}, 32'd0);
    chk("rst_vga_en", {31'd0, vga_en}, 32'd1);
    chk("rst_we_n", {31'd0, sram_we_n}, 32'd1);
    chk("rst_addr", {14'd0, sram_addr}, 32'h23E00);
    chk("rst_starts", {30'd0, m1_start, m2_start}, 32'd0);
    chk("rst_uart", {30'd0, rx_init, rx_en}, 32'd0);
    chk("rst_seq_error", {31'd0, seq_error}, 32'd0);
    resetn = 1'b1;
    repeat (8) tick();
    chk("idle_hold", {29'd0, phase}, 32'd0);

    // Start bit: initialise pulse, then enable pulse
    uart_rx = 1'b0;
    tick();
    uart_rx = 1'b1;
    chk("uart_entry_phase", {29'd0, phase}, 32'd1);
    chk("uart_init_en_1", {30'd0, rx_init, rx_en}, 32'b10);
    chk("uart_vga_off", {31'd0, vga_en}, 32'd0);
    chk("uart_mux_addr", {14'd0, sram_addr}, 32'h00AAA);
    tick();
    chk("uart_init_en_2", {30'd0, rx_init, rx_en}, 32'b01);
    tick();
    chk("uart_init_en_3", {30'd0, rx_init, rx_en}, 32'b00);

    // Two UART writes; timeout counts from the second one
    repeat (8) tick();
    uart_we_n = 1'b0;
    #1;
    chk("uart_write_we", {31'd0, sram_we_n}, 32'd0);
    chk("uart_write_dat", {16'd0, sram_wdat}, 32'h1111);
    tick();
    uart_we_n = 1'b1;
    repeat (59) tick();
    uart_we_n = 1'b0;
    tick();
    uart_we_n = 1'b1;
    repeat (100) tick();
    chk("timeout_minus1", {29'd0, phase}, 32'd1);
    tick();
    chk("timeout_phase", {29'd0, phase}, 32'd2);
    chk("m2_start_on", {31'd0, m2_start}, 32'd1);

    // M2 owns the port
    repeat (3) tick();
    m2_we_n = 1'b0;
    #1;
    chk("m2_mux_addr", {14'd0, sram_addr}, 32'h00100);
    chk("m2_mux_we", {31'd0, sram_we_n}, 32'd0);
    chk("m2_mux_dat", {16'd0, sram_wdat}, 32'h2222);
    m2_we_n   = 1'b1;
    m2_finish = 1'b1;
    tick();
    m2_finish = 1'b0;
    chk("m2_done_start", {31'd0, m2_start}, 32'd0);
    chk("m1_phase", {29'd0, phase}, 32'd3);
    chk("m1_start_on", {31'd0, m1_start}, 32'd1);
    chk("m1_mux_addr", {14'd0, sram_addr}, 32'h00200);

    // Stray M2 finish in M1 is ignored
    m2_finish = 1'b1;
    tick();
    m2_finish = 1'b0;
    chk("stray_finish", {29'd0, phase, m1_start}, {28'd0, 3'd3, 1'b1});

    m1_finish = 1'b1;
    tick();
    m1_finish = 1'b0;
    chk("done_phase", {29'd0, phase}, 32'd4);
    chk("done_vga_en", {31'd0, vga_en}, 32'd1);
    chk("done_m1_start", {31'd0, m1_start}, 32'd0);
    m1_we_n = 1'b0;
    #1;
    chk("done_no_write", {31'd0, sram_we_n}, 32'd1);
    chk("done_vga_addr", {14'd0, sram_addr}, 32'h23E00);
    m1_we_n = 1'b1;

    // Start bits ignored until rearm
    uart_rx = 1'b0;
    repeat (3) tick();
    chk("done_ignores_rx", {29'd0, phase}, 32'd4);
    chk("done_no_init", {31'd0, rx_init}, 32'd0);
    uart_rx = 1'b1;
    rearm   = 1'b1;
    tick();
    rearm = 1'b0;
    chk("rearm_idle", {29'd0, phase}, 32'd0);
    uart_rx = 1'b0;
    tick();
    uart_rx = 1'b1;
    chk("rearm_reload", {29'd0, phase}, 32'd1);

    // Finish in the entry cycle of M2: start high for one cycle only
    wait_phase(3'd2, 300);
    m2_finish = 1'b1;
    tick();
    m2_finish = 1'b0;
    chk("entry_finish", {29'd0, phase, m2_start}, {28'd0, 3'd3, 1'b0});

    // Asynchronous reset during an M1 write
    m1_we_n = 1'b0;
    #1;
    chk("m1_write_live", {31'd0, sram_we_n}, 32'd0);
    resetn = 1'b0;
    #1;
    chk("arst_m1_start", {31'd0, m1_start}, 32'd0);
    chk("arst_phase", {29'd0, phase}, 32'd0);
    chk("arst_we_n", {31'd0, sram_we_n}, 32'd1);
    tick();
    resetn = 1'b1;
    repeat (3) tick();
    chk("post_rst_we_n", {31'd0, sram_we_n}, 32'd1);
    chk("post_rst_phase", {29'd0, phase}, 32'd0);
    m1_we_n = 1'b1;

    // M2 with no finish: watchdog or indefinite wait
    uart_rx = 1'b0;
    tick();
    uart_rx = 1'b1;
    wait_phase(3'd2, 300);
`ifdef SEQ_WATCHDOG_EN
    repeat (49) tick();
    chk("wdog_cycle49", {29'd0, phase, m2_start, seq_error}, {27'd0, 3'd2, 2'b10});
    tick();
    chk("wdog_cycle50", {29'd0, phase, m2_start, seq_error}, {27'd0, 3'd4, 2'b01});
    repeat (5) tick();
    chk("wdog_sticky", {31'd0, seq_error}, 32'd1);
    rearm = 1'b1;
    tick();
    rearm = 1'b0;
    chk("wdog_rearm", {29'd0, phase, seq_error}, {28'd0, 3'd0, 1'b0});
`else
    repeat (60) tick();
    chk("no_wdog_wait", {29'd0, phase, m2_start, seq_error}, {27'd0, 3'd2, 2'b10});
    m2_finish = 1'b1;
    tick();
    m2_finish = 1'b0;
    chk("no_wdog_m1", {29'd0, phase}, 32'd3);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
